gnrl_fifo: RTL and testbench

//  Synchronous valid/ready FIFO built from the general DFF cells. It is the buffering stage that sits

---
 rtl/gnrl_dffl.sv | 16 +
 rtl/gnrl_dfflr.sv | 17 +
 rtl/gnrl_dfflrs.sv | 17 +
 rtl/gnrl_fifo.sv | 115 +++++++++++
 tb/tb_gnrl_fifo.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/gnrl_dffl.sv
// General DFF cell with load enable and no reset; used for datapath storage
// whose contents are don't-care until written.
module gnrl_dffl #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk
);

  always_ff @(posedge clk) begin
    if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/gnrl_dfflr.sv
// General DFF cell with load enable and asynchronous active-low reset to zero.
module gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rstn
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     qout <= '0;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/gnrl_dfflrs.sv
// General DFF cell with load enable and asynchronous active-low reset to all ones.
module gnrl_dfflrs #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rstn
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     qout <= '1;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/gnrl_fifo.sv
// Valid/ready FIFO of DP entries built from the general DFF cells. Handshake
// outputs come straight from flag registers, so there is no input->output path.
module gnrl_fifo #(
  parameter int DW = 32,
  parameter int DP = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     i_vld,
  output logic                     i_rdy,
  input  logic [DW-1:0]            i_dat,
  output logic                     o_vld,
  input  logic                     o_rdy,
  output logic [DW-1:0]            o_dat,
  output logic [$clog2(DP+1)-1:0]  cnt
);

  localparam int PTRW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CNTW = $clog2(DP + 1);

  logic [PTRW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [CNTW-1:0] cnt_r, cnt_nxt;
  logic            full, empty, full_nxt, empty_nxt;
  logic            wr, rd;
  logic [DW-1:0]   mem [DP];

  assign i_rdy = ~full;
  assign o_vld = ~empty;
  assign wr    = i_vld & ~full;
  assign rd    = o_rdy & ~empty;
  assign cnt   = cnt_r;
  assign o_dat = mem[rptr];

  // Explicit compare-and-wrap keeps pointers legal for non-power-of-two depths.
  always_comb begin
    wptr_nxt = '0;
    rptr_nxt = '0;
    if (!flush && (wptr != PTRW'(DP - 1))) wptr_nxt = wptr + PTRW'(1);
    if (!flush && (rptr != PTRW'(DP - 1))) rptr_nxt = rptr + PTRW'(1);
  end

  // Only evaluated when exactly one of wr/rd fires or on flush.
  always_comb begin
    cnt_nxt   = '0;
    full_nxt  = 1'b0;
    empty_nxt = 1'b1;
    if (!flush) begin
      cnt_nxt   = wr ? (cnt_r + CNTW'(1)) : (cnt_r - CNTW'(1));
      full_nxt  = wr & (cnt_r == CNTW'(DP - 1));
      empty_nxt = rd & (cnt_r == CNTW'(1));
    end
  end

  gnrl_dfflr #(.DW(PTRW)) u_wptr (
    .lden (wr | flush),
    .dnxt (wptr_nxt),
    .qout (wptr),
    .clk  (clk),
    .rstn (rstn)
  );

  gnrl_dfflr #(.DW(PTRW)) u_rptr (
    .lden (rd | flush),
    .dnxt (rptr_nxt),
    .qout (rptr),
    .clk  (clk),
    .rstn (rstn)
  );

  gnrl_dfflr #(.DW(CNTW)) u_cnt (
    .lden ((wr ^ rd) | flush),
    .dnxt (cnt_nxt),
    .qout (cnt_r),
    .clk  (clk),
    .rstn (rstn)
  );

  gnrl_dfflr #(.DW(1)) u_full (
    .lden ((wr ^ rd) | flush),
    .dnxt (full_nxt),
    .qout (full),
    .clk  (clk),
    .rstn (rstn)
  );

  gnrl_dfflrs #(.DW(1)) u_empty (
    .lden ((wr ^ rd) | flush),
    .dnxt (empty_nxt),
    .qout (empty),
    .clk  (clk),
    .rstn (rstn)
  );

  for (genvar i = 0; i < DP; i++) begin : g_mem
    gnrl_dffl #(.DW(DW)) u_ent (
      .lden (wr & (wptr == PTRW'(i))),
      .dnxt (i_dat),
      .qout (mem[i]),
      .clk  (clk)
    );
  end

`ifdef ENABLE_SV_ASSERTION
`ifndef FPGA_SOURCE
  a_no_x: assert property (@(posedge clk) disable iff (!rstn)
    !$isunknown({i_vld, o_rdy, flush}));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rstn)
    cnt_r <= CNTW'(DP));
  a_flags: assert property (@(posedge clk) disable iff (!rstn)
    !(full & empty));
`endif
`endif

endmodule

// File: tb/tb_gnrl_fifo.sv
// Self-checking bench for gnrl_fifo: DP=4 table-driven vectors with a data
// scoreboard, plus DP=3 streaming and DP=1 half-bandwidth sequences.
module tb_gnrl_fifo;

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       flush;
    logic       exp_irdy;
    logic       exp_ovld;
    logic [2:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic       a_vld = 0, a_rdy = 0, a_flush = 0, a_irdy, a_ovld;
  logic [7:0] a_dat = 0, a_odat;
  logic [2:0] a_cnt;
  logic       b_vld = 0, b_rdy = 0, b_irdy, b_ovld;
  logic [7:0] b_dat = 0, b_odat;
  logic [1:0] b_cnt;
  logic       c_vld = 0, c_rdy = 0, c_irdy, c_ovld;
  logic [7:0] c_dat = 0, c_odat;
  logic [0:0] c_cnt;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  gnrl_fifo #(.DW(8), .DP(4)) u_dut_a (
    .clk(clk), .rstn(rstn), .flush(a_flush), .i_vld(a_vld), .i_rdy(a_irdy), .i_dat(a_dat),
    .o_vld(a_ovld), .o_rdy(a_rdy), .o_dat(a_odat), .cnt(a_cnt));

  gnrl_fifo #(.DW(8), .DP(3)) u_dut_b (
    .clk(clk), .rstn(rstn), .flush(1'b0), .i_vld(b_vld), .i_rdy(b_irdy), .i_dat(b_dat),
    .o_vld(b_ovld), .o_rdy(b_rdy), .o_dat(b_odat), .cnt(b_cnt));

  gnrl_fifo #(.DW(8), .DP(1)) u_dut_c (
    .clk(clk), .rstn(rstn), .flush(1'b0), .i_vld(c_vld), .i_rdy(c_irdy), .i_dat(c_dat),
    .o_vld(c_ovld), .o_rdy(c_rdy), .o_dat(c_odat), .cnt(c_cnt));

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One DP=4 cycle: drive at negedge, score the head on a read, compare flags after the edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    bit wr, rd;
    @(negedge clk);
    a_vld = v.vld; a_dat = v.dat; a_rdy = v.rdy; a_flush = v.flush;
    wr = v.vld && (qa.size() < 4);
    rd = v.rdy && (qa.size() > 0);
    #1;
    if (rd) checkOutput({tag, " o_dat"}, 32'(a_odat), 32'(qa[0]));
    @(posedge clk);
    #1;
    if (v.flush) qa.delete();
    else begin
      if (rd) void'(qa.pop_front());
      if (wr) qa.push_back(v.dat);
    end
    checkOutput({tag, " i_rdy"}, 32'(a_irdy), 32'(v.exp_irdy));
    checkOutput({tag, " o_vld"}, 32'(a_ovld), 32'(v.exp_ovld));
    checkOutput({tag, " cnt"}, 32'(a_cnt), 32'(v.exp_cnt));
    if (v.exp_ovld && qa.size() > 0) checkOutput({tag, " head"}, 32'(a_odat), 32'(qa[0]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int recvB, recvC;
    bit wr, rd;

    #12;
    checkOutput("reset a_i_rdy", 32'(a_irdy), 32'd1);
    checkOutput("reset a_o_vld", 32'(a_ovld), 32'd0);
    checkOutput("reset a_cnt", 32'(a_cnt), 32'd0);
    checkOutput("reset b_o_vld", 32'(b_ovld), 32'd0);
    checkOutput("reset c_i_rdy", 32'(c_irdy), 32'd1);
    #10 rstn = 1'b1;

    // Fill/drain, full+read, flush with simultaneous write/read.
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4});
    vecs.push_back('{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0});
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Async reset mid-cycle with three entries held.
    applyStimulus('{1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1}, "rst fill1");
    applyStimulus('{1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2}, "rst fill2");
    applyStimulus('{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3}, "rst fill3");
    a_vld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkOutput("async rst o_vld", 32'(a_ovld), 32'd0);
    checkOutput("async rst cnt", 32'(a_cnt), 32'd0);
    checkOutput("async rst i_rdy", 32'(a_irdy), 32'd1);
    qa.delete();
    #3 rstn = 1'b1;
    applyStimulus('{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1}, "post rst wr");
    applyStimulus('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0}, "post rst rd");
    a_rdy = 1'b0;

    // DP=3 streaming through pointer wrap.
    recvB = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      b_vld = (i < 20); b_dat = 8'(i); b_rdy = 1'b1;
      wr = b_vld && (qb.size() < 3);
      rd = (qb.size() > 0);
      #1;
      checkOutput("dp3 o_vld", 32'(b_ovld), 32'(rd));
      if (rd) checkOutput("dp3 o_dat", 32'(b_odat), 32'(qb[0]));
      @(posedge clk);
      if (rd) begin void'(qb.pop_front()); recvB++; end
      if (wr) qb.push_back(b_dat);
    end
    checkOutput("dp3 received", 32'(recvB), 32'd20);
    b_vld = 1'b0; b_rdy = 1'b0;

    // DP=1: one transfer every two cycles, handshakes mutually exclusive.
    recvC = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      c_vld = (i < 10); c_dat = 8'h30 + 8'(i); c_rdy = 1'b1;
      wr = c_vld && (qc.size() < 1);
      rd = (qc.size() > 0);
      #1;
      checkOutput("dp1 exclusive", 32'(c_irdy & c_ovld), 32'd0);
      checkOutput("dp1 o_vld", 32'(c_ovld), 32'(rd));
      checkOutput("dp1 cnt", 32'(c_cnt), 32'(rd));
      if (rd) checkOutput("dp1 o_dat", 32'(c_odat), 32'(qc[0]));
      @(posedge clk);
      if (rd) begin void'(qc.pop_front()); recvC++; end
      if (wr) qc.push_back(c_dat);
    end
    checkOutput("dp1 transfers", 32'(recvC), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
